// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: time-multiplexed 7-segment driver for a chain of BCD digits.
// Digits are snapshotted on a load strobe. A divider then steps through the
// display positions one at a time and drives active-low segments and anodes.
// Invalid digits are shown as a dash. Leading zeros can optionally be blanked.
`timescale 1ns/1ps
module bcd_seg_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_LZ   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       bcd_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          load,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  // A divide-by-one counter still needs one bit of storage.
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

  // Stage 0: shadow copy of the digits and decimal points.
  logic [3:0]            sh_dig_p0 [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] sh_dp_p0;

  logic [CNT_W-1:0]      scan_cnt;
  logic                  advance;
  logic [NUM_DIGITS-1:0] blank;
  logic                  zero_above;

  // Active-low {g,f,e,d,c,b,a}. Codes 10..15 are shown as a dash so a broken
  // counter stage is visible on the display.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign advance = (scan_cnt == CNT_LAST);

  // Capture the digits and decimal points only when the load strobe is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_DIGITS; k++) sh_dig_p0[k] <= 4'd0;
      sh_dp_p0 <= '0;
    end else if (load) begin
      for (int k = 0; k < NUM_DIGITS; k++) sh_dig_p0[k] <= bcd_in[4*k +: 4];
      sh_dp_p0 <= dp_in;
    end
  end

  // Scan divider and digit index. frame_done flags the wrap back to digit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt   <= '0;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= advance && (digit_idx == LAST_IDX);
      if (advance) begin
        scan_cnt  <= '0;
        digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
      end else begin
        scan_cnt  <= scan_cnt + 1'b1;
      end
    end
  end

  // Leading-zero mask. Walk down from the most significant digit while every
  // digit seen so far is zero with no decimal point. Digit 0 always shows.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (sh_dig_p0[k] == 4'd0) && !sh_dp_p0[k];
      blank[k]   = (BLANK_LZ != 0) && zero_above;
    end
  end

  // Stage 1: registered display outputs built from the shadow and current index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= '1;
    end else if (blank[digit_idx]) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      seg <= bcd_to_seg(sh_dig_p0[digit_idx]);
      dp  <= ~sh_dp_p0[digit_idx];
      an  <= ~(ONE_HOT0 << digit_idx);
    end
  end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Directed bench for bcd_seg_scanner with NUM_DIGITS=4 and SCAN_DIV=4.
// A second instance with leading-zero blanking disabled shares the stimulus.
`timescale 1ns/1ps
module tb_bcd_seg_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;

  logic [6:0]  seg, seg_nb;
  logic        dp, dp_nb;
  logic [3:0]  an, an_nb;
  logic [1:0]  digit_idx, digit_idx_nb;
  logic        frame_done, frame_done_nb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_seg_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(1)) dut (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .seg(seg), .dp(dp), .an(an), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  bcd_seg_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .seg(seg_nb), .dp(dp_nb), .an(an_nb), .digit_idx(digit_idx_nb),
    .frame_done(frame_done_nb)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench just after the edge on which digit_idx wrapped to 0.
  task automatic sync_frame();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      if (frame_done === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL sync_frame: frame_done=%b after 40 cycles, required 1", frame_done);
    end
  endtask

  // Load is held high across exactly one rising edge.
  task automatic load_val(input logic [15:0] v, input logic [3:0] d);
    bcd_in = v;
    dp_in  = d;
    load   = 1'b1;
    step(1);
    load   = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    load   = 1'b0;
    bcd_in = 16'h0000;
    dp_in  = 4'h0;
    step(5);
    checks++;
    if (seg !== 7'h7F || an !== 4'hF || dp !== 1'b1 || digit_idx !== 2'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: seg=%h an=%b dp=%b idx=%0d fd=%b, required seg=7f an=1111 dp=1 idx=0 fd=0",
               seg, an, dp, digit_idx, frame_done);
    end
    reset = 1'b0;
    step(1);
    checks++;
    if (seg !== 7'b1000000 || an !== 4'b1110 || dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: seg=%b an=%b dp=%b, required seg=1000000 an=1110 dp=1", seg, an, dp);
    end
  endtask

  task automatic test_count_1234();
    logic [6:0] es [4];
    logic [3:0] ea [4];
    int pulses;
    es = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    sync_frame();
    load_val(16'h1234, 4'b0000);
    step(1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(4);
      checks++;
      if (seg !== es[k] || an !== ea[k] || dp !== 1'b1) begin
        errors++;
        $display("FAIL count_1234 digit%0d: seg=%b an=%b dp=%b, required seg=%b an=%b dp=1",
                 k, seg, an, dp, es[k], ea[k]);
      end
    end
    step(1);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_before: got %b required 0", frame_done);
    end
    step(1);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL frame_done_wrap: got %b required 1", frame_done);
    end
    step(1);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_width: got %b required 0", frame_done);
    end
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (frame_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL frame_done_rate: %0d pulses in 16 cycles, required 1", pulses);
    end
  endtask

  task automatic test_blank_lz();
    logic [6:0] es [4];
    logic [3:0] ea [4];
    es = '{7'b1111000, 7'h7F, 7'h7F, 7'h7F};
    ea = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    sync_frame();
    load_val(16'h0007, 4'b0000);
    step(1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(4);
      checks++;
      if (seg !== es[k] || an !== ea[k] || dp !== 1'b1) begin
        errors++;
        $display("FAIL blank_0007 digit%0d: seg=%b an=%b dp=%b, required seg=%b an=%b dp=1",
                 k, seg, an, dp, es[k], ea[k]);
      end
    end
  endtask

  task automatic test_zero_display();
    logic [6:0] es [4];
    logic [3:0] ea [4];
    logic [3:0] ea_nb [4];
    es    = '{7'b1000000, 7'h7F, 7'h7F, 7'h7F};
    ea    = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    ea_nb = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    sync_frame();
    load_val(16'h0000, 4'b0000);
    step(1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(4);
      checks++;
      if (seg !== es[k] || an !== ea[k] || dp !== 1'b1) begin
        errors++;
        $display("FAIL zero_blank digit%0d: seg=%b an=%b dp=%b, required seg=%b an=%b dp=1",
                 k, seg, an, dp, es[k], ea[k]);
      end
      checks++;
      if (seg_nb !== 7'b1000000 || an_nb !== ea_nb[k] || dp_nb !== 1'b1) begin
        errors++;
        $display("FAIL zero_noblank digit%0d: seg=%b an=%b dp=%b, required seg=1000000 an=%b dp=1",
                 k, seg_nb, an_nb, dp_nb, ea_nb[k]);
      end
    end
  endtask

  task automatic test_dp_invalid();
    logic [6:0] es [4];
    logic [3:0] ea [4];
    logic       ed [4];
    es = '{7'b0010010, 7'b0111111, 7'b1000000, 7'h7F};
    ea = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
    ed = '{1'b1, 1'b1, 1'b0, 1'b1};
    sync_frame();
    load_val(16'h00A5, 4'b0100);
    step(1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(4);
      checks++;
      if (seg !== es[k] || an !== ea[k] || dp !== ed[k]) begin
        errors++;
        $display("FAIL dp_invalid digit%0d: seg=%b an=%b dp=%b, required seg=%b an=%b dp=%b",
                 k, seg, an, dp, es[k], ea[k], ed[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    sync_frame();
    step(3);
    bcd_in = 16'h9999;
    dp_in  = 4'b0000;
    load   = 1'b1;
    step(1);
    load   = 1'b0;
    checks++;
    if (seg !== 7'b0010010 || an !== 4'b1110 || digit_idx !== 2'd1) begin
      errors++;
      $display("FAIL b2b_edge: seg=%b an=%b idx=%0d, required seg=0010010 an=1110 idx=1",
               seg, an, digit_idx);
    end
    step(1);
    checks++;
    if (seg !== 7'b0010000 || an !== 4'b1101 || dp !== 1'b1) begin
      errors++;
      $display("FAIL b2b_next: seg=%b an=%b dp=%b, required seg=0010000 an=1101 dp=1", seg, an, dp);
    end
  endtask

  task automatic test_reset_mid_scan();
    int first_fd;
    sync_frame();
    step(9);
    checks++;
    if (digit_idx !== 2'd2 || an !== 4'b1011 || seg !== 7'b0010000) begin
      errors++;
      $display("FAIL mid_scan_pre: idx=%0d an=%b seg=%b, required idx=2 an=1011 seg=0010000",
               digit_idx, an, seg);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (seg !== 7'h7F || an !== 4'hF || dp !== 1'b1 || digit_idx !== 2'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: seg=%h an=%b dp=%b idx=%0d fd=%b, required seg=7f an=1111 dp=1 idx=0 fd=0",
               seg, an, dp, digit_idx, frame_done);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1);
    checks++;
    if (seg !== 7'b1000000 || an !== 4'b1110 || dp !== 1'b1 || digit_idx !== 2'd0) begin
      errors++;
      $display("FAIL restart_first: seg=%b an=%b dp=%b idx=%0d, required seg=1000000 an=1110 dp=1 idx=0",
               seg, an, dp, digit_idx);
    end
    first_fd = 0;
    for (int i = 2; i <= 20; i++) begin
      step(1);
      if (i == 6) begin
        checks++;
        if (an !== 4'hF || seg !== 7'h7F) begin
          errors++;
          $display("FAIL restart_blank: an=%b seg=%h, required an=1111 seg=7f", an, seg);
        end
      end
      if (frame_done === 1'b1 && first_fd == 0) first_fd = i;
    end
    checks++;
    if (first_fd != 16) begin
      errors++;
      $display("FAIL restart_frame: first frame_done at edge %0d, required 16", first_fd);
    end
  endtask

  initial begin
    test_reset();
    test_count_1234();
    test_blank_lz();
    test_zero_display();
    test_dp_invalid();
    test_back_to_back();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
